mario_bg_tile_fetch: RTL and testbench

MARIO_BG_TILE_FETCH -- requirements
Module: mario_bg_tile_fetch

---
 rtl/mario_bg_tile_fetch.sv | 138 +++++++++++++
 tb/tb_mario_bg_tile_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mario_bg_tile_fetch.sv
// Background tile fetcher: walks tile map -> pattern ROM every 8 pixels and
// serialises two bitplanes into a 2-bit pixel code with matching tile and blank.
module mario_bg_tile_fetch #(
    parameter logic [4:0] COL_OFS    = 5'd0,
    parameter bit         PLANE_SWAP = 1'b0
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_PIX_EN,
    input  logic [7:0]  I_HPOS,
    input  logic [7:0]  I_VPOS,
    input  logic        I_H_BLANKn,
    input  logic        I_V_BLANKn,
    input  logic        I_FLIP,
    output logic [9:0]  O_VRAM_A,
    input  logic [7:0]  I_VRAM_D,
    output logic [10:0] O_ROM_A,
    input  logic [7:0]  I_ROM_D0,
    input  logic [7:0]  I_ROM_D1,
    output logic [1:0]  O_PIX,
    output logic [7:0]  O_TILE,
    output logic        O_BLANKn
);

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7 - i];
        end
        return r;
    endfunction

    logic [9:0]  vram_a_q, vram_a_d;
    logic [10:0] rom_a_q, rom_a_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  hold0_q, hold0_d;
    logic [7:0]  hold1_q, hold1_d;
    logic [7:0]  shift0_q, shift0_d;
    logic [7:0]  shift1_q, shift1_d;
    logic [7:0]  tile_q, tile_d;
    logic [6:0]  blank_dly_q, blank_dly_d;
    logic        blank_q, blank_d;
    logic [1:0]  pix_q, pix_d;

    logic [2:0]  phase_s;
    logic [4:0]  col_s;

    assign phase_s = I_HPOS[2:0];
    assign col_s   = I_HPOS[7:3] + COL_OFS;

    // Next-state for the fetch pipeline, shifters and blank delay line.
    always_comb begin
        vram_a_d    = vram_a_q;
        rom_a_d     = rom_a_q;
        code_d      = code_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        shift0_d    = shift0_q;
        shift1_d    = shift1_q;
        tile_d      = tile_q;
        blank_dly_d = blank_dly_q;
        blank_d     = blank_q;
        if (I_PIX_EN) begin
            case (phase_s)
                3'd0: vram_a_d = {I_VPOS[7:3], col_s};
                3'd2: begin
                    code_d  = I_VRAM_D;
                    rom_a_d = {I_VRAM_D, I_VPOS[2:0]};
                end
                3'd4: begin
                    hold0_d = I_ROM_D0;
                    hold1_d = I_ROM_D1;
                end
                default: begin
                end
            endcase
            if (phase_s == 3'd7) begin
                shift0_d = I_FLIP ? rev8(hold0_q) : hold0_q;
                shift1_d = I_FLIP ? rev8(hold1_q) : hold1_q;
                tile_d   = code_q;
            end else begin
                shift0_d = {shift0_q[6:0], 1'b0};
                shift1_d = {shift1_q[6:0], 1'b0};
            end
            // Seven stages plus the output flop line blank up with the shifter MSB.
            blank_dly_d = {blank_dly_q[5:0], I_H_BLANKn & I_V_BLANKn};
            blank_d     = blank_dly_q[6];
        end else begin
            blank_d = blank_q;
        end
    end

    // Pixel output is registered from the next-state values so it tracks the shifters exactly.
    always_comb begin
        pix_d = 2'd0;
        if (blank_d) begin
            pix_d = PLANE_SWAP ? {shift0_d[7], shift1_d[7]} : {shift1_d[7], shift0_d[7]};
        end else begin
            pix_d = 2'd0;
        end
    end

    // State registers with synchronous reset taking priority over the pixel enable.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            vram_a_q    <= 10'd0;
            rom_a_q     <= 11'd0;
            code_q      <= 8'd0;
            hold0_q     <= 8'd0;
            hold1_q     <= 8'd0;
            shift0_q    <= 8'd0;
            shift1_q    <= 8'd0;
            tile_q      <= 8'd0;
            blank_dly_q <= 7'd0;
            blank_q     <= 1'b0;
            pix_q       <= 2'd0;
        end else begin
            vram_a_q    <= vram_a_d;
            rom_a_q     <= rom_a_d;
            code_q      <= code_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            shift0_q    <= shift0_d;
            shift1_q    <= shift1_d;
            tile_q      <= tile_d;
            blank_dly_q <= blank_dly_d;
            blank_q     <= blank_d;
            pix_q       <= pix_d;
        end
    end

    assign O_VRAM_A = vram_a_q;
    assign O_ROM_A  = rom_a_q;
    assign O_PIX    = pix_q;
    assign O_TILE   = tile_q;
    assign O_BLANKn = blank_q;

endmodule

// File: tb/tb_mario_bg_tile_fetch.sv
// Scoreboard bench: instance A uses {plane0,plane1} order (the order the reference
// pixel vectors are written in), instance B uses default order with COL_OFS=31.
module tb_mario_bg_tile_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic [7:0]  hpos = 8'd0;
    logic [7:0]  vpos = 8'd41;
    logic        hbl = 1'b1;
    logic        vbl = 1'b1;
    logic        flip = 1'b0;

    logic [9:0]  vram_a_a, vram_a_b;
    logic [10:0] rom_a_a, rom_a_b;
    logic [7:0]  vram_d_a = 8'd0, vram_d_b = 8'd0;
    logic [7:0]  rom0_a = 8'd0, rom1_a = 8'd0, rom0_b = 8'd0, rom1_b = 8'd0;
    logic [1:0]  pix_a, pix_b;
    logic [7:0]  tile_a, tile_b;
    logic        blank_a, blank_b;

    always #5 clk = ~clk;

    mario_bg_tile_fetch #(.COL_OFS(5'd0), .PLANE_SWAP(1'b1)) dut_a (
        .I_CLK(clk), .I_RST(rst), .I_PIX_EN(pix_en), .I_HPOS(hpos), .I_VPOS(vpos),
        .I_H_BLANKn(hbl), .I_V_BLANKn(vbl), .I_FLIP(flip),
        .O_VRAM_A(vram_a_a), .I_VRAM_D(vram_d_a), .O_ROM_A(rom_a_a),
        .I_ROM_D0(rom0_a), .I_ROM_D1(rom1_a),
        .O_PIX(pix_a), .O_TILE(tile_a), .O_BLANKn(blank_a));

    mario_bg_tile_fetch #(.COL_OFS(5'd31), .PLANE_SWAP(1'b0)) dut_b (
        .I_CLK(clk), .I_RST(rst), .I_PIX_EN(pix_en), .I_HPOS(hpos), .I_VPOS(vpos),
        .I_H_BLANKn(hbl), .I_V_BLANKn(vbl), .I_FLIP(flip),
        .O_VRAM_A(vram_a_b), .I_VRAM_D(vram_d_b), .O_ROM_A(rom_a_b),
        .I_ROM_D0(rom0_b), .I_ROM_D1(rom1_b),
        .O_PIX(pix_b), .O_TILE(tile_b), .O_BLANKn(blank_b));

    // Tile map: every entry of row 5 is 0x42; pattern 0x42 line 1 is D0=F0, D1=0F.
    function automatic logic [7:0] vram_f(input logic [9:0] a);
        return (a[9:5] == 5'd5) ? 8'h42 : 8'h00;
    endfunction
    function automatic logic [7:0] rom0_f(input logic [10:0] a);
        return (a == 11'h211) ? 8'hF0 : 8'h00;
    endfunction
    function automatic logic [7:0] rom1_f(input logic [10:0] a);
        return (a == 11'h211) ? 8'h0F : 8'h00;
    endfunction

    // Synchronous memories with one clock of read latency.
    always @(posedge clk) begin
        vram_d_a <= vram_f(vram_a_a);
        vram_d_b <= vram_f(vram_a_b);
        rom0_a   <= rom0_f(rom_a_a);
        rom1_a   <= rom1_f(rom_a_a);
        rom0_b   <= rom0_f(rom_a_b);
        rom1_b   <= rom1_f(rom_a_b);
    end

    typedef struct packed {
        logic [1:0] pa;
        logic [1:0] pb;
        logic       bl;
        logic [7:0] tile;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   failures = 0;

    int         m_edges = 0;
    int         m_idx = 8;
    logic [7:0] m_p0 = 8'd0, m_p1 = 8'd0, m_tile = 8'd0;
    logic       bl_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7 - i];
        return r;
    endfunction

    task automatic do_reset(input logic [7:0] h);
        @(negedge clk);
        rst = 1'b1; pix_en = 1'b1; hpos = h;
        @(posedge clk); #1;
        chk("rst_vram_a", 32'(vram_a_a), 32'd0);
        chk("rst_rom_a", 32'(rom_a_a), 32'd0);
        chk("rst_pix_a", 32'(pix_a), 32'd0);
        chk("rst_tile_a", 32'(tile_a), 32'd0);
        chk("rst_blank_a", 32'(blank_a), 32'd0);
        chk("rst_pix_b", 32'(pix_b), 32'd0);
        @(negedge clk);
        rst = 1'b0; pix_en = 1'b0;
        repeat (2) @(posedge clk);
        m_edges = 0; m_idx = 8; m_p0 = 8'd0; m_p1 = 8'd0; m_tile = 8'd0;
        bl_q.delete();
    endtask

    // One pixel-enable edge: drive it, push the model's expected output, then idle for gap clocks.
    task automatic pix_edge(input logic [7:0] h, input logic hb, input int gap);
        exp_t e;
        logic b0, b1, ebl;
        @(negedge clk);
        hpos = h; hbl = hb; flip = (h[7:6] == 2'b01); pix_en = 1'b1;
        m_edges++;
        if (h[2:0] == 3'd7) begin
            if (m_edges >= 8) begin
                m_p0 = 8'hF0; m_p1 = 8'h0F; m_tile = 8'h42;
            end else begin
                m_p0 = 8'h00; m_p1 = 8'h00; m_tile = 8'h00;
            end
            if (flip) begin
                m_p0 = rev8(m_p0); m_p1 = rev8(m_p1);
            end
            m_idx = 0;
        end else begin
            m_idx++;
        end
        b0 = (m_idx < 8) ? m_p0[7 - m_idx] : 1'b0;
        b1 = (m_idx < 8) ? m_p1[7 - m_idx] : 1'b0;
        bl_q.push_back(hb & vbl);
        if (bl_q.size() > 8) void'(bl_q.pop_front());
        ebl = (bl_q.size() == 8) ? bl_q[0] : 1'b0;
        e.pa = ebl ? {b0, b1} : 2'd0;
        e.pb = ebl ? {b1, b0} : 2'd0;
        e.bl = ebl;
        e.tile = m_tile;
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk); #1;
        if (h == 8'd0)  chk("b_col_ofs31_h0", 32'(vram_a_b[4:0]), 32'd31);
        if (h == 8'd8)  chk("b_col_wrap_h8", 32'(vram_a_b[4:0]), 32'd0);
        if (h == 8'd24) chk("a_vram_a_h24", 32'(vram_a_a), 32'h0A3);
        if (h == 8'd26) chk("a_rom_a_h26", 32'(rom_a_a), 32'h211);
        if (gap > 0) begin
            pix_en = 1'b0;
            repeat (gap) begin
                @(posedge clk);
            end
            if (gap >= 10) begin
                #1;
                chk("frozen_pix", 32'(pix_a), 32'(last_exp.pa));
                chk("frozen_tile", 32'(tile_a), 32'(last_exp.tile));
                chk("frozen_blank", 32'(blank_a), 32'(last_exp.bl));
            end
        end
    endtask

    // Monitor: every enabled, non-reset edge presents one output word to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (pix_en === 1'b1 && rst === 1'b0) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("pix_a@h%0d", hpos), 32'(pix_a), 32'(e.pa));
                    chk($sformatf("pix_b@h%0d", hpos), 32'(pix_b), 32'(e.pb));
                    chk($sformatf("blank@h%0d", hpos), 32'(blank_a), 32'(e.bl));
                    chk($sformatf("tile@h%0d", hpos), 32'(tile_a), 32'(e.tile));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        do_reset(8'd0);
        for (int h = 0; h < 128; h++) pix_edge(8'(h), 1'b1, (h == 35) ? 20 : 0);
        for (int h = 128; h < 256; h++) pix_edge(8'(h), 1'b1, 1);
        for (int h = 0; h < 67; h++) pix_edge(8'(h), (h >= 16), 0);
        do_reset(8'd67);
        for (int h = 68; h <= 100; h++) pix_edge(8'(h), 1'b1, 0);
        @(negedge clk);
        pix_en = 1'b0;
        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
